// File: rtl/pc_pkg.sv
// Shared types and constants for the PC/fetch front end.
package pc_pkg;

    localparam int unsigned PC_INCR = 4;
    localparam int unsigned CNT_W   = 16;

    // Next-PC source; the numeric order doubles as redirect priority.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_TRAP   = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } fetch_state_t;

    // True when redirect a may displace redirect b (equal or higher priority).
    function automatic logic prio_ge(input pc_sel_t a, input pc_sel_t b);
        return a >= b;
    endfunction

endpackage

// File: rtl/mux4.sv
// Generic four-input one-hot-free multiplexer.
module mux4 #(
    parameter int unsigned W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] dout_c
);

    // Select one of four candidates.
    always_comb begin
        dout_c = in0;
        case (sel)
            2'b01:   dout_c = in1;
            2'b10:   dout_c = in2;
            2'b11:   dout_c = in3;
            default: dout_c = in0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program-counter register and fetch-request stage.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned winning branch/jump
// target is turned into a trap and flagged on misalign; otherwise the low
// target bits are silently cleared and misalign stays 0.
module pc_fetch_stage
    import pc_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000),
    parameter logic [N-1:0] TRAP_VEC = N'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [N-1:0]     branch_target,
    input  logic             jump,
    input  logic [N-1:0]     jump_target,
    input  logic             trap,
    output logic             imem_valid,
    input  logic             imem_ready,
    output logic [N-1:0]     imem_addr,
    output logic [1:0]       pc_sel,
    output logic [N-1:0]     pc,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign
);

    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    fetch_state_t     state_q, state_d;
    logic [N-1:0]     pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_vld_q, pend_vld_d;
    pc_sel_t          pend_sel_q, pend_sel_d;
    logic [N-1:0]     pend_tgt_q, pend_tgt_d;

    pc_sel_t          win_sel;
    pc_sel_t          sel_c;
    logic             redir;
    logic             handshake;
    logic             capture;
    logic [N-1:0]     seq_pc;
    logic [N-1:0]     br_cand;
    logic [N-1:0]     jmp_cand;
    logic [N-1:0]     next_pc_c;
`ifdef PC_MISALIGN_TRAP_EN
    logic             mis_c;
    logic             misalign_q;
`endif

    // Priority pick among this cycle's redirect requests.
    always_comb begin
        win_sel = PC_SEQ;
        redir   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis_c   = 1'b0;
`endif
        if (trap) begin
            win_sel = PC_TRAP;
            redir   = 1'b1;
        end else if (jump) begin
            win_sel = PC_JUMP;
            redir   = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (jump_target[1:0] != 2'b00) begin
                win_sel = PC_TRAP;
                mis_c   = 1'b1;
            end
`endif
        end else if (branch_taken) begin
            win_sel = PC_BRANCH;
            redir   = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (branch_target[1:0] != 2'b00) begin
                win_sel = PC_TRAP;
                mis_c   = 1'b1;
            end
`endif
        end
    end

    // A live redirect wins; otherwise a latched redirect; otherwise sequential.
    assign sel_c     = redir ? win_sel : (pend_vld_q ? pend_sel_q : PC_SEQ);
    assign seq_pc    = pc_q + N'(PC_INCR);
    assign br_cand   = branch_taken ? (branch_target & ALIGN_MASK) : pend_tgt_q;
    assign jmp_cand  = jump ? (jump_target & ALIGN_MASK) : pend_tgt_q;
    assign handshake = valid_q && imem_ready;
    assign capture   = redir && (!pend_vld_q || prio_ge(win_sel, pend_sel_q));

    mux4 #(
        .W(N)
    ) u_next_pc_mux (
        .sel    (2'(sel_c)),
        .in0    (seq_pc),
        .in1    (br_cand),
        .in2    (jmp_cand),
        .in3    (TRAP_VEC),
        .dout_c (next_pc_c)
    );

    // Next-state, PC, request and pending-redirect update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_sel_d = pend_sel_q;
        pend_tgt_d = pend_tgt_q;

        case (state_q)
            BOOT: begin
                state_d = ISSUE;
                valid_d = 1'b1;
                if (capture) begin
                    pend_vld_d = 1'b1;
                    pend_sel_d = win_sel;
                    pend_tgt_d = next_pc_c;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    pc_d       = next_pc_c;
                    cnt_d      = cnt_q + CNT_W'(1);
                    pend_vld_d = 1'b0;
                    if (stall) begin
                        state_d = HOLD;
                        valid_d = 1'b0;
                    end
                end else if (capture) begin
                    pend_vld_d = 1'b1;
                    pend_sel_d = win_sel;
                    pend_tgt_d = next_pc_c;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d = next_pc_c;
                end
                if (!stall) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_sel_q <= PC_SEQ;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_sel_q <= pend_sel_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle flag for a misaligned target converted into a trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= mis_c;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_valid  = valid_q;
    assign fetch_count = cnt_q;
    assign pc_sel      = rst_n ? 2'(sel_c) : 2'(PC_SEQ);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios then random traffic, all
// compared against a transaction-level reference model.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [1:0]  pc_sel;
    logic [31:0] pc;
    logic [15:0] fetch_count;
    logic        misalign;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    bit          m_valid;
    bit          m_boot;
    bit          m_pend;
    int          m_pend_prio;
    logic [31:0] m_pend_tgt;
    bit          m_mis;

    pc_fetch_stage #(
        .N        (32),
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .imem_valid    (imem_valid),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .pc_sel        (pc_sel),
        .pc            (pc),
        .fetch_count   (fetch_count),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winning redirect of the current inputs: priority 0 = none, 1 branch, 2 jump, 3 trap.
    function automatic void pick(output int prio, output logic [31:0] tgt, output bit mis);
        prio = 0;
        tgt  = 32'h0;
        mis  = 1'b0;
        if (trap) begin
            prio = 3;
            tgt  = TRAP_VEC;
        end else if (jump) begin
            prio = 2;
            tgt  = jump_target & ~32'h3;
            mis  = (jump_target % 4) != 0;
        end else if (branch_taken) begin
            prio = 1;
            tgt  = branch_target & ~32'h3;
            mis  = (branch_target % 4) != 0;
        end
`ifdef PC_MISALIGN_TRAP_EN
        if (mis) begin
            prio = 3;
            tgt  = TRAP_VEC;
        end
`else
        mis = 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_cnt       = 16'd0;
        m_valid     = 1'b0;
        m_boot      = 1'b1;
        m_pend      = 1'b0;
        m_pend_prio = 0;
        m_pend_tgt  = 32'h0;
        m_mis       = 1'b0;
    endtask

    task automatic note_pending(input int prio, input logic [31:0] tgt);
        if (!m_pend || prio >= m_pend_prio) begin
            m_pend      = 1'b1;
            m_pend_prio = prio;
            m_pend_tgt  = tgt;
        end
    endtask

    // Assert reset mid-cycle, check the forced values, release on the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(imem_valid), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_count", 32'(fetch_count), 32'd0);
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs at the falling edge, check, advance the model, wait a cycle.
    task automatic cycle(input bit s, input bit r, input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit t);
        int          prio;
        logic [31:0] tgt;
        bit          mis;
        bit          redir;
        int          exp_sel;
        stall         = s;
        imem_ready    = r;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        trap          = t;
        #1;
        pick(prio, tgt, mis);
        redir   = prio != 0;
        exp_sel = redir ? prio : (m_pend ? m_pend_prio : 0);
        check("valid", 32'(imem_valid), 32'(m_valid));
        if (m_valid) check("addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("count", 32'(fetch_count), 32'(m_cnt));
        check("pc_sel", 32'(pc_sel), 32'(exp_sel));
        check("misalign", 32'(misalign), 32'(m_mis));

        if (m_boot) begin
            if (redir) note_pending(prio, tgt);
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (r) begin
                m_pc   = redir ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
                m_cnt  = m_cnt + 16'd1;
                m_pend = 1'b0;
                if (s) m_valid = 1'b0;
            end else if (redir) begin
                note_pending(prio, tgt);
            end
        end else begin
            if (redir) m_pc = tgt;
            if (!s) m_valid = 1'b1;
        end
        m_mis = mis;
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        trap          = 1'b0;
        imem_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Sequential fetch from reset
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check("seq_count4", 32'(fetch_count), 32'd4);
        check("seq_addr10", imem_addr, 32'h10);

        // Jump while the request waits: address held, then redirected
        cycle(0, 0, 0, 32'h0, 1, 32'h40, 0);
        cycle(0, 0, 0, 32'h0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0, 32'h0, 0);
        check("held_valid", 32'(imem_valid), 32'd1);
        check("held_addr", imem_addr, 32'h10);
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check("pend_jump_addr", imem_addr, 32'h40);

        // Trap beats branch in the same cycle
        cycle(0, 1, 1, 32'h80, 0, 32'h0, 1);
        check("trap_sel", 32'(pc_sel), 32'd3);
        check("trap_addr", imem_addr, TRAP_VEC);

        // Pending trap is not displaced by a later branch
        cycle(0, 0, 0, 32'h0, 0, 32'h0, 1);
        cycle(0, 0, 1, 32'h200, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check("pend_trap_addr", imem_addr, TRAP_VEC);

        // Stall on a handshake parks the next PC
        cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
        check("hold_valid", 32'(imem_valid), 32'd0);
        check("hold_pc", pc, 32'h104);
        cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check("resume_valid", 32'(imem_valid), 32'd1);
        check("resume_addr", imem_addr, 32'h104);

        // Misaligned jump target
        cycle(0, 1, 0, 32'h0, 1, 32'h42, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_addr", imem_addr, TRAP_VEC);
        check("misalign_flag", 32'(misalign), 32'd1);
`else
        check("misalign_addr", imem_addr, 32'h40);
        check("misalign_flag", 32'(misalign), 32'd0);
`endif

        // Sequential wrap at the top of the address space
        cycle(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        check("wrap_addr", imem_addr, 32'h0);

        // Random traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 6) == 0, $urandom(),
                      $urandom_range(0, 9) == 0, $urandom(),
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
